// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU command-side master: function codes, FSM states
// and the latched command record.
package alu_ctrl_pkg;

    localparam int REG_AW = 3;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_PSA = 3'b010;
    localparam logic [2:0] FN_SHL = 3'b011;
    localparam logic [2:0] FN_SHR = 3'b100;
    localparam logic [2:0] FN_AND = 3'b101;
    localparam logic [2:0] FN_NOT = 3'b110;
    localparam logic [2:0] FN_OR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_e;

    typedef struct packed {
        logic [2:0]        func;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } cmd_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW operand register file: two async operand reads, one async debug
// read, ALU writeback port with priority over the direct load port.
module alu_regfile #(
    parameter int NREG = 8,
    parameter int DW   = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr_a,
    output logic [DW-1:0] rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    logic [DW-1:0] rf [NREG];

    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];
    assign dbg_data  = rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            // A load colliding with the writeback address is dropped.
            if (ld_en && !(wb_en && (wb_addr == ld_addr))) begin
                rf[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                rf[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side master for the registered 8-bit ALU: IDLE -> ISSUE -> CAPTURE.
// Define ALU_OP_COUNT_EN to add the saturating op_count output.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_func,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DW-1:0]     ld_data,
    output logic [DW-1:0]     alu_reg1,
    output logic [DW-1:0]     alu_reg2,
    output logic [2:0]        alu_func,
    input  logic [DW-1:0]     alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_carry,
    output logic [REG_AW-1:0] rsp_rd,
`ifdef ALU_OP_COUNT_EN
    output logic [15:0]       op_count,
`endif
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    state_e        state, state_n;
    cmd_t          cmd_q;
    logic          issue, capture;
    logic [DW-1:0] rf_a, rf_b;
    logic [DW-1:0] op_a_q, op_b_q;
    logic [2:0]    func_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_n = ISSUE;
            end
            ISSUE: begin
                issue   = 1'b1;
                state_n = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Accept stage: latch the command while ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= '0;
        end else if (cmd_ready && cmd_valid) begin
            cmd_q <= '{func: cmd_func, rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd};
        end
    end

    alu_regfile #(.NREG(NREG), .DW(DW), .AW(REG_AW)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (cmd_q.rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (cmd_q.rs2),
        .rd_data_b (rf_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wb_en     (capture),
        .wb_addr   (cmd_q.rd),
        .wb_data   (alu_out),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    // Issue stage: live operands during ISSUE, held copies otherwise so the
    // ALU's registered output does not move while we capture it.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
            func_q <= '0;
        end else if (issue) begin
            op_a_q <= rf_a;
            op_b_q <= rf_b;
            func_q <= cmd_q.func;
        end
    end

    assign alu_reg1 = issue ? rf_a       : op_a_q;
    assign alu_reg2 = issue ? rf_b       : op_b_q;
    assign alu_func = issue ? cmd_q.func : func_q;

    // Capture stage: response registers, carry qualified to add only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_rd    <= '0;
        end else begin
            rsp_valid <= capture;
            if (capture) begin
                rsp_data  <= alu_out;
                rsp_rd    <= cmd_q.rd;
                rsp_carry <= (cmd_q.func == FN_ADD) ? alu_carry : 1'b0;
            end
        end
    end

`ifdef ALU_OP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (capture && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_func, cmd_rs1, cmd_rs2, cmd_rd;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_reg1, alu_reg2;
    logic [2:0] alu_func;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic [2:0] rsp_rd;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
`ifdef ALU_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_func(alu_func),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_rd(rsp_rd),
`ifdef ALU_OP_COUNT_EN
        .op_count(op_count),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural registered ALU.
    always @(posedge clk) begin
        case (alu_func)
            3'b000: {alu_carry, alu_out} <= {1'b0, alu_reg1} + {1'b0, alu_reg2};
            3'b001: {alu_carry, alu_out} <= {1'b0, alu_reg1} - {1'b0, alu_reg2};
            3'b010: {alu_carry, alu_out} <= {1'b0, alu_reg1};
            3'b011: {alu_carry, alu_out} <= {alu_reg1, 1'b0};
            3'b100: {alu_carry, alu_out} <= {alu_reg1[0], 1'b0, alu_reg1[7:1]};
            3'b101: {alu_carry, alu_out} <= {1'b0, alu_reg1 & alu_reg2};
            3'b110: {alu_carry, alu_out} <= {1'b1, ~alu_reg1};
            default: {alu_carry, alu_out} <= {1'b0, alu_reg1 | alu_reg2};
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic [2:0] rd;
        int         due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data",    32'(rsp_data),  32'(e.d));
                chk("rsp_carry",   32'(rsp_carry), 32'(e.c));
                chk("rsp_rd",      32'(rsp_rd),    32'(e.rd));
                chk("rsp_latency", 32'(cyc),       32'(e.due));
            end
        end
    end

    // Call #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [7:0] ed, input logic ec,
                         input bit push, input bit hold, output int acc);
        logic rdy;
        bit   done;
        cmd_func = f; cmd_rs1 = a; cmd_rs2 = b; cmd_rd = d; cmd_valid = 1'b1;
        done = 0;
        acc  = -1;
        for (int i = 0; i < 10 && !done; i++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                acc  = cyc;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        else if (push) sb.push_back('{d: ed, c: ec, rd: d, due: acc + 2});
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] v);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        rst = 1'b1; cmd_valid = 1'b0; cmd_func = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_reg1",  32'(alu_reg1),  32'd0);
        chk("rst_alu_func",  32'(alu_func),  32'd0);
        chk_reg("rst_r0", 3'd0, 8'h00);

        // 1: add
        load(3'd1, 8'h0F);
        load(3'd2, 8'h01);
        issue(3'b000, 3'd1, 3'd2, 3'd3, 8'h10, 1'b0, 1, 0, a1);
        settle();
        chk_reg("t1_r3", 3'd3, 8'h10);

        // 2: add with carry, then sub
        load(3'd1, 8'hFF);
        issue(3'b000, 3'd1, 3'd2, 3'd4, 8'h00, 1'b1, 1, 0, a1);
        issue(3'b001, 3'd1, 3'd2, 3'd4, 8'hFE, 1'b0, 1, 0, a1);
        settle();
        chk_reg("t2_r4", 3'd4, 8'hFE);

        // 3: shl (carry suppressed), not, and, shr
        load(3'd1, 8'h81);
        issue(3'b011, 3'd1, 3'd0, 3'd5, 8'h02, 1'b0, 1, 0, a1);
        issue(3'b110, 3'd1, 3'd0, 3'd5, 8'h7E, 1'b0, 1, 0, a1);
        issue(3'b101, 3'd1, 3'd2, 3'd6, 8'h01, 1'b0, 1, 0, a1);
        issue(3'b100, 3'd1, 3'd0, 3'd6, 8'h40, 1'b0, 1, 0, a1);
        settle();
        chk("t3_func_hold", 32'(alu_func), 32'd4);
        chk("t3_reg1_hold", 32'(alu_reg1), 32'h81);

        // 4: back-to-back with cmd_valid held
        issue(3'b111, 3'd1, 3'd2, 3'd6, 8'h81, 1'b0, 1, 1, a1);
        issue(3'b010, 3'd3, 3'd0, 3'd7, 8'h10, 1'b0, 1, 0, a2);
        chk("t4_accept_gap", 32'(a2 - a1), 32'd3);
        settle();
        chk_reg("t4_r7", 3'd7, 8'h10);

        // 5: ld colliding with writeback in CAPTURE
        issue(3'b000, 3'd3, 3'd2, 3'd3, 8'h11, 1'b0, 1, 0, a1);
        @(posedge clk);
        #1;
        load(3'd3, 8'hAA);
        settle();
        chk_reg("t5_r3", 3'd3, 8'h11);

        // ld during ISSUE not seen by the command
        issue(3'b010, 3'd2, 3'd0, 3'd5, 8'h01, 1'b0, 1, 0, a1);
        load(3'd2, 8'h55);
        settle();
        chk_reg("t5_r2", 3'd2, 8'h55);
        chk_reg("t5_r5", 3'd5, 8'h01);
`ifdef ALU_OP_COUNT_EN
        chk("op_count", 32'(op_count), 32'd11);
`endif

        // 6: reset during ISSUE drops the command
        issue(3'b000, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 0, 0, a1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_alu_reg1",  32'(alu_reg1),  32'd0);
        for (int i = 0; i < 8; i++) chk_reg("t6_reg", 3'(i), 8'h00);
`ifdef ALU_OP_COUNT_EN
        chk("t6_op_count", 32'(op_count), 32'd0);
`endif
        settle();
        chk_reg("t6_r0_after", 3'd0, 8'h00);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
